// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - shared types and constants for the SECDED decode sequencer
package secded_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HI,
    S_RD_LO,
    S_CAP,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_e;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_ONE  = 2'b01;
  localparam logic [1:0] FLAG_TWO  = 2'b10;

  localparam int POS_P0 = 0;
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_P4 = 4;
  localparam int POS_P8 = 8;

  // Data bits sit at every Hamming position that is not a power of two.
  function automatic logic [10:0] data_bits(input logic [15:0] code);
    return {code[15:9], code[7:5], code[3]};
  endfunction

endpackage

// File: rtl/secded_dec16.sv
// rtl/secded_dec16.sv - combinational Hamming SECDED decode of one 16-bit code word
module secded_dec16
  import secded_pkg::*;
(
  input  logic [15:0] code_i,
  output logic [15:0] result_o,
  output logic        single_o,
  output logic        double_o
);

  logic [3:0]  syn;
  logic        ovp;
  logic [15:0] fixed;
  logic [1:0]  flag;

  always_comb begin
    syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (code_i[k]) syn = syn ^ k[3:0];
    end
    ovp   = ^code_i;
    fixed = code_i;
    // Syndrome 0 with odd parity lands on p0, leaving the data untouched.
    if (ovp) fixed[syn] = ~fixed[syn];
    single_o = ovp;
    double_o = !ovp && (syn != 4'd0);
    if (single_o)      flag = FLAG_ONE;
    else if (double_o) flag = FLAG_TWO;
    else               flag = FLAG_NONE;
    result_o = {flag, 3'b000, data_bits(fixed)};
  end

endmodule

// File: rtl/secded_mem_sequencer.sv
// rtl/secded_mem_sequencer.sv - walks encoded words in byte memory, decodes and writes results back
module secded_mem_sequencer #(
  parameter int NUM_WORDS = 15,
  parameter int IN_BASE   = 30,
  parameter int OUT_BASE  = 0,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data,
  output logic [7:0]    err1_cnt,
  output logic [7:0]    err2_cnt
);
  import secded_pkg::*;

  localparam logic [AW-1:0] IN_B    = AW'(IN_BASE);
  localparam logic [AW-1:0] OUT_B   = AW'(OUT_BASE);
  localparam logic [AW-1:0] ONE     = AW'(1);
  localparam logic [6:0]    LAST_IX = 7'(NUM_WORDS - 1);

  state_e        state_q;
  logic [6:0]    idx_q;
  logic [7:0]    hi_q, lo_q;
  logic [7:0]    err1_q, err2_q;
  logic [AW-1:0] addr_q;
  logic          wr_en_q, busy_q, done_q;

  logic [15:0]   res;
  logic          single, dbl;
  logic [AW-1:0] off_cur, off_nxt;

  assign off_cur = AW'({idx_q, 1'b0});
  assign off_nxt = AW'({idx_q + 7'd1, 1'b0});

  secded_dec16 u_dec (
    .code_i   ({hi_q, lo_q}),
    .result_o (res),
    .single_o (single),
    .double_o (dbl)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 7'd0;
      hi_q    <= 8'd0;
      lo_q    <= 8'd0;
      err1_q  <= 8'd0;
      err2_q  <= 8'd0;
      addr_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RD_HI;
            idx_q   <= 7'd0;
            err1_q  <= 8'd0;
            err2_q  <= 8'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            addr_q  <= IN_B + ONE;
          end else if (state_q == S_DONE) begin
            done_q <= 1'b1;
          end
        end
        S_RD_HI: begin
          addr_q  <= IN_B + off_cur;
          state_q <= S_RD_LO;
        end
        S_RD_LO: begin
          hi_q    <= mem_rd_data;
          state_q <= S_CAP;
        end
        S_CAP: begin
          lo_q    <= mem_rd_data;
          addr_q  <= OUT_B + off_cur;
          wr_en_q <= 1'b1;
          state_q <= S_WR_LO;
        end
        S_WR_LO: begin
          if (single && err1_q != 8'hFF) err1_q <= err1_q + 8'd1;
          if (dbl && err2_q != 8'hFF)    err2_q <= err2_q + 8'd1;
          addr_q  <= OUT_B + off_cur + ONE;
          state_q <= S_WR_HI;
        end
        S_WR_HI: begin
          wr_en_q <= 1'b0;
          if (idx_q == LAST_IX) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + 7'd1;
            addr_q  <= IN_B + off_nxt + ONE;
            state_q <= S_RD_HI;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write data follows the decoder directly; the byte pair is already captured.
  always_comb begin
    mem_wr_data = 8'h00;
    if (state_q == S_WR_LO)      mem_wr_data = res[7:0];
    else if (state_q == S_WR_HI) mem_wr_data = res[15:8];
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_wr_en = wr_en_q;
  assign err1_cnt  = err1_q;
  assign err2_cnt  = err2_q;

endmodule

// File: tb/tb_secded_mem_sequencer.sv
// tb/tb_secded_mem_sequencer.sv - directed table-driven bench for the SECDED sequencer
module tb_secded_mem_sequencer;

  localparam int N1 = 15, IN1 = 30, OUT1 = 0;
  localparam int N2 = 4,  IN2 = 100, OUT2 = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, busy1, done1, we1;
  logic [7:0] addr1, wd1, rd1, e1a, e2a;
  logic       start2, busy2, done2, we2;
  logic [7:0] addr2, wd2, rd2, e1b, e2b;
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  secded_mem_sequencer #(.NUM_WORDS(N1), .IN_BASE(IN1), .OUT_BASE(OUT1), .AW(8)) dut (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .mem_addr(addr1), .mem_wr_en(we1), .mem_wr_data(wd1), .mem_rd_data(rd1),
    .err1_cnt(e1a), .err2_cnt(e2a)
  );

  secded_mem_sequencer #(.NUM_WORDS(N2), .IN_BASE(IN2), .OUT_BASE(OUT2), .AW(8)) dut_inp (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .mem_addr(addr2), .mem_wr_en(we2), .mem_wr_data(wd2), .mem_rd_data(rd2),
    .err1_cnt(e1b), .err2_cnt(e2b)
  );

  always @(posedge clk) begin
    rd1 <= mem1[addr1];
    if (we1) mem1[addr1] <= wd1;
    rd2 <= mem2[addr2];
    if (we2) mem2[addr2] <= wd2;
  end

  typedef struct {
    logic [15:0] code;
    logic [15:0] res;
  } vec_t;

  vec_t        tbl [15];
  logic [15:0] exp_r [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] c;
    c = 16'h0000;
    c[3] = d[0];
    c[7:5] = d[3:1];
    c[15:9] = d[10:4];
    c[1] = ^(c & 16'hAAA8);
    c[2] = ^(c & 16'hCCC8);
    c[4] = ^(c & 16'hF0E0);
    c[8] = ^(c & 16'hFE00);
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] dext(input logic [15:0] c);
    return {c[15:9], c[7:5], c[3]};
  endfunction

  task automatic run1(input bit poke, output int n);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) chk("busy_during_run", busy1, 1);
      if (poke && n == 20) start1 = 1'b1;
      if (poke && n == 21) start1 = 1'b0;
    end
  endtask

  task automatic check_out1(input string tag);
    for (int i = 0; i < N1; i++)
      chk(tag, {i[7:0], mem1[OUT1+2*i+1], mem1[OUT1+2*i]}, {i[7:0], exp_r[i]});
  endtask

  initial begin
    int n, e1, e2, nf, p1, p2;
    logic [10:0] d;
    logic [15:0] w;
    logic [7:0]  eb;

    reset = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] <= 8'h00;
      mem2[i] <= 8'h00;
    end
    #22;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_wr_en", we1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_wdata", wd1, 0);
    chk("rst_err", {e1a, e2a}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ctrl", {busy1, done1, we1, busy2, done2, we2}, 0);

    tbl[0]  = '{16'hFFFF, 16'h07FF};
    tbl[1]  = '{16'hFDFF, 16'h47FF};
    tbl[2]  = '{16'h0001, 16'h4000};
    tbl[3]  = '{16'h0100, 16'h4000};
    tbl[4]  = '{16'h0088, 16'h8009};
    tbl[5]  = '{16'h0000, 16'h0000};
    tbl[6]  = '{16'hFFFE, 16'h47FF};
    tbl[7]  = '{16'h7FFF, 16'h47FF};
    tbl[8]  = '{16'h0003, 16'h8000};
    tbl[9]  = '{16'h0008, 16'h4000};
    tbl[10] = '{16'h000F, 16'h0001};
    tbl[11] = '{16'h002F, 16'h4001};
    tbl[12] = '{16'h820F, 16'h8411};
    tbl[13] = '{16'hFFEF, 16'h47FF};
    tbl[14] = '{16'h8000, 16'h4000};

    e1 = 0;
    e2 = 0;
    for (int i = 0; i < N1; i++) begin
      mem1[IN1+2*i]   <= tbl[i].code[7:0];
      mem1[IN1+2*i+1] <= tbl[i].code[15:8];
      exp_r[i] = tbl[i].res;
      if (tbl[i].res[15:14] == 2'b01) e1++;
      if (tbl[i].res[15:14] == 2'b10) e2++;
    end
    run1(1'b1, n);
    chk("latency_table_run", n, 76);
    chk("done_not_busy", {done1, busy1}, 2'b10);
    check_out1("table_word");
    chk("err1_table", e1a, e1);
    chk("err2_table", e2a, e2);
    repeat (3) @(negedge clk);
    chk("done_held", done1, 1);

    // Random data with a known number of flips (0, 1 or 2) per word.
    e1 = 0;
    e2 = 0;
    for (int i = 0; i < N1; i++) begin
      d  = 11'($urandom);
      w  = enc(d);
      nf = i % 3;
      p1 = $urandom_range(0, 15);
      p2 = (p1 + 1 + $urandom_range(0, 14)) % 16;
      if (nf >= 1) w[p1] = ~w[p1];
      if (nf == 2) w[p2] = ~w[p2];
      if (nf == 0) exp_r[i] = {5'b00000, d};
      else if (nf == 1) begin
        exp_r[i] = {5'b01000, d};
        e1++;
      end else begin
        exp_r[i] = {5'b10000, dext(w)};
        e2++;
      end
      mem1[IN1+2*i]   <= w[7:0];
      mem1[IN1+2*i+1] <= w[15:8];
    end
    run1(1'b0, n);
    chk("latency_random_run", n, 76);
    check_out1("random_word");
    chk("err1_random", e1a, e1);
    chk("err2_random", e2a, e2);

    // Abort during the high-byte write of word index 7.
    for (int b = 0; b < 2 * N1; b++) mem1[OUT1+b] <= 8'hA5;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int k = 0; k < 39; k++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    chk("abort_outputs", {busy1, done1, we1, addr1, wd1}, 0);
    chk("abort_err", {e1a, e2a}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int b = 0; b < 2 * N1; b++) begin
      eb = (b <= 14) ? ((b % 2 == 0) ? exp_r[b/2][7:0] : exp_r[b/2][15:8]) : 8'hA5;
      chk("abort_mem", {b[7:0], mem1[OUT1+b]}, {b[7:0], eb});
    end
    run1(1'b0, n);
    chk("latency_after_abort", n, 76);
    check_out1("rerun_word");
    chk("err_rerun", {e1a, e2a}, {e1[7:0], e2[7:0]});

    // In-place decode on the second instance.
    mem2[IN2+0] <= 8'hFF; mem2[IN2+1] <= 8'hFF;
    mem2[IN2+2] <= 8'hFF; mem2[IN2+3] <= 8'hFD;
    mem2[IN2+4] <= 8'h88; mem2[IN2+5] <= 8'h00;
    mem2[IN2+6] <= 8'h0F; mem2[IN2+7] <= 8'h00;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 200) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("latency_inplace", n, 21);
    chk("inplace_w0", {mem2[OUT2+1], mem2[OUT2+0]}, 16'h07FF);
    chk("inplace_w1", {mem2[OUT2+3], mem2[OUT2+2]}, 16'h47FF);
    chk("inplace_w2", {mem2[OUT2+5], mem2[OUT2+4]}, 16'h8009);
    chk("inplace_w3", {mem2[OUT2+7], mem2[OUT2+6]}, 16'h0001);
    chk("inplace_edges", {mem2[OUT2-1], mem2[OUT2+8]}, 16'h0000);
    chk("inplace_err", {e1b, e2b}, 16'h0101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
